// File: rtl/bfly_stage_pipe.sv
// Radix-2 butterfly stage: LANES complex pairs per beat give (A+B)*tw and (A-B)*tw through a
// three-stage valid/ready pipeline with round-half-up, optional halving, saturation and sticky overflow.
module bfly_stage_pipe #(
    parameter int LANES     = 16,
    parameter int WIDTH     = 9,
    parameter int TW_W      = 10,
    parameter int TW_NUM    = 4,
    parameter int GROUP_LEN = 128,
    parameter int OUT_W     = WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        scale_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic signed [WIDTH-1:0]     din1_i [LANES],
    input  logic signed [WIDTH-1:0]     din1_q [LANES],
    input  logic signed [WIDTH-1:0]     din2_i [LANES],
    input  logic signed [WIDTH-1:0]     din2_q [LANES],
    output logic [$clog2(TW_NUM)-1:0]   tw_addr,
    input  logic signed [TW_W-1:0]      tw_re,
    input  logic signed [TW_W-1:0]      tw_im,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic signed [OUT_W-1:0]     dout1_i [LANES],
    output logic signed [OUT_W-1:0]     dout1_q [LANES],
    output logic signed [OUT_W-1:0]     dout2_i [LANES],
    output logic signed [OUT_W-1:0]     dout2_q [LANES],
    output logic                        ovf
);

    localparam int SW = WIDTH + 1;
    localparam int PW = WIDTH + TW_W + 2;
    localparam int RW = PW + 1;
    localparam int AW = $clog2(TW_NUM);
    localparam int CW = $clog2(TW_NUM * GROUP_LEN);
    localparam logic [CW-1:0]        CNT_MAX = CW'(TW_NUM * GROUP_LEN - 1);
    localparam logic signed [RW-1:0] SAT_HI  = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_LO  = RW'(-(2 ** (OUT_W - 1)));

    // Index [0] of every per-branch array carries A+B, index [1] carries A-B.
    logic                    s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_scale_q, s1_scale_d;
    logic signed [TW_W-1:0]  s1_tw_re_q, s1_tw_re_d, s1_tw_im_q, s1_tw_im_d;
    logic signed [SW-1:0]    s1_re_q [2][LANES];
    logic signed [SW-1:0]    s1_re_d [2][LANES];
    logic signed [SW-1:0]    s1_im_q [2][LANES];
    logic signed [SW-1:0]    s1_im_d [2][LANES];

    logic                    s2_v_q, s2_v_d, s2_last_q, s2_last_d, s2_scale_q, s2_scale_d;
    logic signed [PW-1:0]    s2_re_q [2][LANES];
    logic signed [PW-1:0]    s2_re_d [2][LANES];
    logic signed [PW-1:0]    s2_im_q [2][LANES];
    logic signed [PW-1:0]    s2_im_d [2][LANES];

    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d, ovf_q, ovf_d;
    logic signed [OUT_W-1:0] dout_re_q [2][LANES];
    logic signed [OUT_W-1:0] dout_re_d [2][LANES];
    logic signed [OUT_W-1:0] dout_im_q [2][LANES];
    logic signed [OUT_W-1:0] dout_im_d [2][LANES];

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    stall, advance, accept, sat_any;
    logic signed [PW-1:0]    xr, xi, wr, wi;
    logic [OUT_W:0]          res_re, res_im;

    // Returns {saturated, value} after round-half-up shift and clamp.
    function automatic logic [OUT_W:0] rnd_sat(input logic signed [PW-1:0] p, input logic sc);
        logic signed [RW-1:0] r;
        int unsigned          sh;
        sh = sc ? TW_W - 1 : TW_W - 2;
        r  = (RW'(p) + (RW'(1) <<< (sh - 1))) >>> sh;
        if (r > SAT_HI) begin
            return {1'b1, SAT_HI[OUT_W-1:0]};
        end else if (r < SAT_LO) begin
            return {1'b1, SAT_LO[OUT_W-1:0]};
        end
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    assign stall    = out_valid_q & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;
    assign tw_addr  = AW'(cnt_q / CW'(GROUP_LEN));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = (in_last || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        s1_last_d  = s1_last_q;
        s1_scale_d = s1_scale_q;
        s1_tw_re_d = s1_tw_re_q;
        s1_tw_im_d = s1_tw_im_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        if (advance) begin
            s1_v_d = accept;
            if (accept) begin
                s1_last_d  = in_last;
                s1_scale_d = scale_en;
                s1_tw_re_d = tw_re;
                s1_tw_im_d = tw_im;
                for (int unsigned l = 0; l < LANES; l++) begin
                    s1_re_d[0][l] = {din1_i[l][WIDTH-1], din1_i[l]} + {din2_i[l][WIDTH-1], din2_i[l]};
                    s1_im_d[0][l] = {din1_q[l][WIDTH-1], din1_q[l]} + {din2_q[l][WIDTH-1], din2_q[l]};
                    s1_re_d[1][l] = {din1_i[l][WIDTH-1], din1_i[l]} - {din2_i[l][WIDTH-1], din2_i[l]};
                    s1_im_d[1][l] = {din1_q[l][WIDTH-1], din1_q[l]} - {din2_q[l][WIDTH-1], din2_q[l]};
                end
            end
        end
    end

    always_comb begin
        s2_v_d     = s2_v_q;
        s2_last_d  = s2_last_q;
        s2_scale_d = s2_scale_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;
        xr         = '0;
        xi         = '0;
        wr         = s1_tw_re_q;
        wi         = s1_tw_im_q;
        if (advance) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_last_d  = s1_last_q;
                s2_scale_d = s1_scale_q;
                for (int unsigned b = 0; b < 2; b++) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        xr            = s1_re_q[b][l];
                        xi            = s1_im_q[b][l];
                        s2_re_d[b][l] = xr * wr - xi * wi;
                        s2_im_d[b][l] = xr * wi + xi * wr;
                    end
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        dout_re_d   = dout_re_q;
        dout_im_d   = dout_im_q;
        ovf_d       = ovf_q;
        sat_any     = 1'b0;
        res_re      = '0;
        res_im      = '0;
        if (advance) begin
            out_valid_d = s2_v_q;
            if (s2_v_q) begin
                out_last_d = s2_last_q;
                for (int unsigned b = 0; b < 2; b++) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        res_re          = rnd_sat(s2_re_q[b][l], s2_scale_q);
                        res_im          = rnd_sat(s2_im_q[b][l], s2_scale_q);
                        dout_re_d[b][l] = res_re[OUT_W-1:0];
                        dout_im_d[b][l] = res_im[OUT_W-1:0];
                        sat_any         = sat_any | res_re[OUT_W] | res_im[OUT_W];
                    end
                end
                ovf_d = ovf_q | sat_any;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_scale_q  <= 1'b0;
            s1_tw_re_q  <= '0;
            s1_tw_im_q  <= '0;
            s1_re_q     <= '{default: '0};
            s1_im_q     <= '{default: '0};
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_scale_q  <= 1'b0;
            s2_re_q     <= '{default: '0};
            s2_im_q     <= '{default: '0};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            dout_re_q   <= '{default: '0};
            dout_im_q   <= '{default: '0};
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            s1_scale_q  <= s1_scale_d;
            s1_tw_re_q  <= s1_tw_re_d;
            s1_tw_im_q  <= s1_tw_im_d;
            s1_re_q     <= s1_re_d;
            s1_im_q     <= s1_im_d;
            s2_v_q      <= s2_v_d;
            s2_last_q   <= s2_last_d;
            s2_scale_q  <= s2_scale_d;
            s2_re_q     <= s2_re_d;
            s2_im_q     <= s2_im_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            dout_re_q   <= dout_re_d;
            dout_im_q   <= dout_im_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            dout1_i[l] = dout_re_q[0][l];
            dout1_q[l] = dout_im_q[0][l];
            dout2_i[l] = dout_re_q[1][l];
            dout2_q[l] = dout_im_q[1][l];
        end
    end

endmodule

// File: tb/tb_bfly_stage_pipe.sv
// Directed bench for bfly_stage_pipe: arithmetic, rounding/saturation, twiddle addressing,
// frame restart, backpressure ordering and reset with beats in flight.
module tb_bfly_stage_pipe;

    localparam int LANES     = 16;
    localparam int WIDTH     = 9;
    localparam int TW_W      = 10;
    localparam int TW_NUM    = 4;
    localparam int GROUP_LEN = 128;
    localparam int OUT_W     = WIDTH + 1;
    localparam int AW        = $clog2(TW_NUM);

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    scale_en;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [WIDTH-1:0] din1_i [LANES];
    logic signed [WIDTH-1:0] din1_q [LANES];
    logic signed [WIDTH-1:0] din2_i [LANES];
    logic signed [WIDTH-1:0] din2_q [LANES];
    logic [AW-1:0]           tw_addr;
    logic signed [TW_W-1:0]  tw_re;
    logic signed [TW_W-1:0]  tw_im;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic signed [OUT_W-1:0] dout1_i [LANES];
    logic signed [OUT_W-1:0] dout1_q [LANES];
    logic signed [OUT_W-1:0] dout2_i [LANES];
    logic signed [OUT_W-1:0] dout2_q [LANES];
    logic                    ovf;

    int errors = 0;
    int checks = 0;

    bfly_stage_pipe #(
        .LANES(LANES), .WIDTH(WIDTH), .TW_W(TW_W),
        .TW_NUM(TW_NUM), .GROUP_LEN(GROUP_LEN), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .scale_en(scale_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .din1_i(din1_i), .din1_q(din1_q), .din2_i(din2_i), .din2_q(din2_q),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .dout1_i(dout1_i), .dout1_q(dout1_q), .dout2_i(dout2_i), .dout2_q(dout2_q),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [4*OUT_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {OUT_W'(a), OUT_W'(b), OUT_W'(c), OUT_W'(d)};
    endfunction

    function automatic logic [4*OUT_W-1:0] lane_word(input int l);
        return {dout1_i[l], dout1_q[l], dout2_i[l], dout2_q[l]};
    endfunction

    // Expected output of beat n on lane l for the backpressure stream under the identity twiddle.
    function automatic logic [4*OUT_W-1:0] beat_word(input int n, input int l);
        return pack4(n + 3*l - 5, -l, n - l + 5, -2*n + l);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int ai, input int aq, input int bi, input int bq);
        for (int l = 0; l < LANES; l++) begin
            din1_i[l] = WIDTH'(ai);
            din1_q[l] = WIDTH'(aq);
            din2_i[l] = WIDTH'(bi);
            din2_q[l] = WIDTH'(bq);
        end
    endtask

    task automatic drive_beat(input int n);
        for (int l = 0; l < LANES; l++) begin
            din1_i[l] = WIDTH'(n + l);
            din1_q[l] = WIDTH'(-n);
            din2_i[l] = WIDTH'(2*l - 5);
            din2_q[l] = WIDTH'(n - l);
        end
        in_last = (n % 4 == 3);
    endtask

    task automatic set_tw(input int re, input int im);
        tw_re = TW_W'(re);
        tw_im = TW_W'(im);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rstn     = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic send_one();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        scale_en  = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        set_tw(256, 0);
        set_lanes(1, 2, 3, 4);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        checks++;
        if (tw_addr !== '0) begin errors++; $display("FAIL rst_tw_addr got=%0d exp=0", tw_addr); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== '0) begin
                errors++;
                $display("FAIL rst_dout_lane%0d got=%h exp=0", l, lane_word(l));
            end
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        logic [4*OUT_W-1:0] exp;
        exp = pack4(13, -2, 7, -6);
        scale_en = 1'b0;
        set_tw(256, 0);
        set_lanes(10, -4, 3, 2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ident_early_valid got=%b exp=0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ident_valid got=%b exp=1", out_valid); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== exp) begin
                errors++;
                $display("FAIL ident_lane%0d got=%h exp=%h", l, lane_word(l), exp);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ident_one_cycle got=%b exp=0", out_valid); end
    endtask

    task automatic test_rotation();
        logic [4*OUT_W-1:0] exp;
        exp = pack4(0, -10, 0, -10);
        set_tw(0, -256);
        set_lanes(10, 0, 0, 0);
        send_one();
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== exp) begin
                errors++;
                $display("FAIL rot_mj_lane%0d got=%h exp=%h", l, lane_word(l), exp);
            end
        end
        exp = pack4(71, 71, 71, 71);
        set_tw(181, 181);
        set_lanes(100, 0, 0, 0);
        send_one();
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== exp) begin
                errors++;
                $display("FAIL rot_45_lane%0d got=%h exp=%h", l, lane_word(l), exp);
            end
        end
    endtask

    task automatic test_scale_sat();
        logic [4*OUT_W-1:0] exp;
        exp = pack4(7, 0, 1, 0);
        scale_en = 1'b1;
        set_tw(256, 0);
        set_lanes(7, 0, 6, 0);
        send_one();
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== exp) begin
                errors++;
                $display("FAIL scale_lane%0d got=%h exp=%h", l, lane_word(l), exp);
            end
        end
        tick();
        scale_en = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_sat got=%b exp=0", ovf); end
        exp = pack4(511, 511, 0, 0);
        set_tw(362, 362);
        set_lanes(255, 0, 255, 0);
        send_one();
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== exp) begin
                errors++;
                $display("FAIL sat_lane%0d got=%h exp=%h", l, lane_word(l), exp);
            end
        end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        exp = pack4(13, -2, 7, -6);
        set_tw(256, 0);
        set_lanes(10, -4, 3, 2);
        send_one();
        tick();
        checks++;
        if (lane_word(0) !== exp) begin errors++; $display("FAIL after_sat_lane0 got=%h exp=%h", lane_word(0), exp); end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_tw_addr();
        logic [AW-1:0] exp_a;
        apply_reset();
        set_tw(256, 0);
        set_lanes(0, 0, 0, 0);
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int b = 0; b < 600; b++) begin
            exp_a = AW'((b / GROUP_LEN) % TW_NUM);
            checks++;
            if (tw_addr !== exp_a) begin
                errors++;
                $display("FAIL tw_addr_beat%0d got=%0d exp=%0d", b, tw_addr, exp_a);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_last_restart();
        logic [AW-1:0] exp_a;
        int            cm;
        apply_reset();
        in_valid = 1'b1;
        cm = 0;
        for (int b = 0; b < 300; b++) begin
            in_last = (b == 5 || b == 140);
            exp_a   = AW'(cm / GROUP_LEN);
            checks++;
            if (tw_addr !== exp_a) begin
                errors++;
                $display("FAIL last_tw_addr_beat%0d got=%0d exp=%0d", b, tw_addr, exp_a);
            end
            tick();
            cm = (in_last || cm == TW_NUM*GROUP_LEN - 1) ? 0 : cm + 1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        int  sb[$];
        int  next_n;
        int  n;
        logic exp_rdy;
        apply_reset();
        set_tw(256, 0);
        scale_en = 1'b0;
        next_n   = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (c < 20);
            if (c < 20) drive_beat(next_n);
            else in_last = 1'b0;
            @(negedge clk);
            exp_rdy = !(c >= 4 && c <= 8);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready_c%0d got=%b exp=%b", c, in_ready, exp_rdy);
            end
            if (in_valid && in_ready) begin
                sb.push_back(next_n);
                next_n++;
            end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat_c%0d got=out_valid exp=no_beat", c);
                end else begin
                    n = sb[0];
                    for (int l = 0; l < LANES; l++) begin
                        checks++;
                        if (lane_word(l) !== beat_word(n, l)) begin
                            errors++;
                            $display("FAIL bp_c%0d_beat%0d_lane%0d got=%h exp=%h", c, n, l, lane_word(l), beat_word(n, l));
                        end
                    end
                    checks++;
                    if (out_last !== (n % 4 == 3)) begin
                        errors++;
                        $display("FAIL bp_out_last_beat%0d got=%b exp=%b", n, out_last, (n % 4 == 3));
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            tick();
        end
        checks++;
        if (next_n != 15) begin errors++; $display("FAIL bp_accepted got=%0d exp=15", next_n); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL bp_undelivered got=%0d exp=0", sb.size()); end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic test_reset_traffic();
        logic [4*OUT_W-1:0] exp;
        apply_reset();
        scale_en = 1'b0;
        set_tw(362, 362);
        set_lanes(0, 0, 0, 0);
        in_valid = 1'b1;
        repeat (130) tick();
        set_lanes(255, 0, 255, 0);
        repeat (3) tick();
        in_valid = 1'b0;
        checks++;
        if (ovf !== 1'b1 || out_valid !== 1'b1 || tw_addr !== AW'(1)) begin
            errors++;
            $display("FAIL pre_reset_state got=ovf%b/v%b/a%0d exp=ovf1/v1/a1", ovf, out_valid, tw_addr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf); end
        checks++;
        if (tw_addr !== '0) begin errors++; $display("FAIL mid_rst_tw_addr got=%0d exp=0", tw_addr); end
        #1;
        rstn = 1'b1;
        exp = pack4(13, -2, 7, -6);
        set_tw(256, 0);
        set_lanes(10, -4, 3, 2);
        @(negedge clk);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_c1 got=%b exp=0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_c2 got=%b exp=0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got=%b exp=1", out_valid); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (lane_word(l) !== exp) begin
                errors++;
                $display("FAIL post_rst_lane%0d got=%h exp=%h", l, lane_word(l), exp);
            end
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL post_rst_ovf got=%b exp=0", ovf); end
        tick();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rotation();
        test_scale_sat();
        test_tw_addr();
        test_last_restart();
        test_back_to_back();
        test_reset_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
